// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: op codes, RV32I funct3 widths and FSM states.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_NONE  = 2'd0,
    LSU_LOAD  = 2'd1,
    LSU_STORE = 2'd2,
    LSU_RSVD  = 2'd3
  } lsu_op_e;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Encodings that must fault without touching memory.
  function automatic logic is_illegal(lsu_op_e op, logic [2:0] f3);
    case (op)
      LSU_NONE:  return 1'b0;
      LSU_LOAD:  return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      LSU_STORE: return (f3 > SW);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store byte-lane replication / write-mask generation and load extraction / extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_lane,
  output logic [3:0]  wmask,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    wdata_lane = wdata;
    wmask      = 4'b1111;
    case (funct3)
      SB: begin
        wdata_lane = {4{wdata[7:0]}};
        wmask      = 4'b0001 << offset;
      end
      SH: begin
        wdata_lane = {2{wdata[15:0]}};
        wmask      = 4'b0011 << offset;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext = shifted;
    case (funct3)
      LB:      rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      LH:      rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     rdata_ext = {24'd0, shifted[7:0]};
      LHU:     rdata_ext = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: one instruction at a time, one memory transaction, result to writeback.
// Optional LSU_MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of aligning them.
module lsu
  import lsu_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  // state | meaning
  // IDLE  | ready for a new instruction
  // REQ   | memory request presented, waiting for mem_req_ready
  // WAIT  | request accepted, waiting for response or timeout
  // DONE  | result presented to writeback until out_ready

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(RESP_TIMEOUT);

  lsu_state_e      state;
  lsu_op_e         op_e;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic            is_load_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic            accept;
  logic            illegal;
  logic [1:0]      in_off;
  logic [2:0]      al_funct3;
  logic [1:0]      al_off;
  logic [31:0]     wdata_lane;
  logic [3:0]      wmask;
  logic [31:0]     rdata_ext;

  assign op_e     = lsu_op_e'(in_op);
  assign in_ready = (state == ST_IDLE) & ~rst;
  assign accept   = in_valid & in_ready;
  assign cnt_next = cnt + 1'b1;

  always_comb begin
    in_off = in_addr[1:0];
    case (in_funct3[1:0])
      2'b01:   in_off = {in_addr[1], 1'b0};
      2'b10:   in_off = 2'b00;
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((op_e == LSU_LOAD) || (op_e == LSU_STORE)) &&
                    (((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                     ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00)));
  assign illegal  = is_illegal(op_e, in_funct3) | misalign;
`else
  assign illegal  = is_illegal(op_e, in_funct3);
`endif

  // The aligner serves store formatting in IDLE and load extraction afterwards.
  assign al_funct3 = (state == ST_IDLE) ? in_funct3 : funct3_q;
  assign al_off    = (state == ST_IDLE) ? in_off : off_q;

  lsu_align u_align (
    .funct3     (al_funct3),
    .offset     (al_off),
    .wdata      (in_wdata),
    .rdata      (mem_resp_rdata),
    .wdata_lane (wdata_lane),
    .wmask      (wmask),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
      is_load_q     <= 1'b0;
      cnt           <= '0;
      out_valid     <= 1'b0;
      out_data      <= 32'd0;
      out_fault     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'd0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= 32'd0;
      mem_req_wmask <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            funct3_q  <= in_funct3;
            off_q     <= in_off;
            is_load_q <= (op_e == LSU_LOAD);
            if (op_e == LSU_NONE) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_data  <= in_addr;
              out_fault <= 1'b0;
            end else if (illegal) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_data  <= 32'd0;
              out_fault <= 1'b1;
            end else begin
              state         <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {in_addr[31:2], 2'b00};
              mem_req_wen   <= (op_e == LSU_STORE);
              mem_req_wdata <= (op_e == LSU_STORE) ? wdata_lane : 32'd0;
              mem_req_wmask <= (op_e == LSU_STORE) ? wmask : 4'd0;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state         <= ST_WAIT;
            mem_req_valid <= 1'b0;
            cnt           <= '0;
          end
        end
        ST_WAIT: begin
          // A response in the final timeout cycle still wins.
          if (mem_resp_valid) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_data  <= is_load_q ? rdata_ext : 32'd0;
            out_fault <= 1'b0;
          end else if (cnt_next == TIMEOUT_C) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_data  <= 32'd0;
            out_fault <= 1'b1;
          end else begin
            cnt <= cnt_next;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed vector bench for lsu (RESP_TIMEOUT=4); honours LSU_MISALIGN_TRAP_EN.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_fault;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu #(.RESP_TIMEOUT(4), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_funct3      (in_funct3),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_fault      (out_fault),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          req;
    logic [31:0] raddr;
    logic [3:0]  wmask;
    logic [31:0] rwdata;
    logic [31:0] data;
    logic        fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [1:0] op, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, bit req, logic [31:0] raddr,
                              logic [3:0] wmask, logic [31:0] rwdata, logic [31:0] data, logic fault);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.req = req; v.raddr = raddr; v.wmask = wmask; v.rwdata = rwdata; v.data = data; v.fault = fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one instruction; memory raises ready after ready_dly REQ cycles and responds after
  // resp_dly WAIT cycles (-1 = never); writeback stalls hold cycles. exp_lat counts cycles after accept.
  task automatic run(input vec_t v, input int ready_dly, input int resp_dly, input int hold, input int exp_lat);
    int  req_cycles = 0;
    int  wait_cycles = 0;
    int  held = 0;
    int  lat = -1;
    bit  saw_req = 1'b0;
    bit  in_wait = 1'b0;
    bit  got = 1'b0;
    logic [31:0] first_data = 32'd0;
    @(negedge clk);
    chk({v.name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = v.op; in_funct3 = v.f3; in_addr = v.addr; in_wdata = v.wdata;
    out_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      mem_resp_valid = 1'b0; mem_req_ready = 1'b0; out_ready = 1'b0;
      if (out_valid) begin
        if (lat < 0) begin
          lat = c;
          first_data = out_data;
          chk({v.name, " latency"}, lat, exp_lat);
          chk({v.name, " out_data"}, out_data, v.data);
          chk({v.name, " out_fault"}, {31'd0, out_fault}, {31'd0, v.fault});
        end else begin
          chk({v.name, " out_data held"}, out_data, first_data);
        end
        if (held == hold) begin
          out_ready = 1'b1;
          got = 1'b1;
        end
        held++;
      end else if (mem_req_valid) begin
        saw_req = 1'b1;
        chk({v.name, " req_addr"}, mem_req_addr, v.raddr);
        chk({v.name, " req_wen"}, {31'd0, mem_req_wen}, {31'd0, (v.op == 2'd2)});
        chk({v.name, " req_wmask"}, {28'd0, mem_req_wmask}, {28'd0, v.wmask});
        if (v.op == 2'd2) chk({v.name, " req_wdata"}, mem_req_wdata, v.rwdata);
        if (req_cycles == ready_dly) begin
          mem_req_ready = 1'b1;
          in_wait = 1'b1;
        end
        req_cycles++;
      end else if (in_wait) begin
        if (wait_cycles == resp_dly) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = v.rdata;
        end
        wait_cycles++;
      end
      @(negedge clk);
    end
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0; out_ready = 1'b0;
    chk({v.name, " completed"}, {31'd0, got}, 32'd1);
    chk({v.name, " req issued"}, {31'd0, saw_req}, {31'd0, v.req});
    chk({v.name, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_funct3 = 3'd0; in_addr = 32'd0; in_wdata = 32'd0;
    out_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;

    vecs.push_back(mk("none",   2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h1234_5678, 1'b0));
    vecs.push_back(mk("lb",     2'd1, 3'd0, 32'h8000_0003, 32'h0, 32'h8000_0000, 1, 32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b0));
    vecs.push_back(mk("lbu",    2'd1, 3'd4, 32'h8000_0003, 32'h0, 32'h8000_0000, 1, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_0080, 1'b0));
    vecs.push_back(mk("sh",     2'd2, 3'd1, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 1, 32'h8000_0000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0));
    vecs.push_back(mk("sb",     2'd2, 3'd0, 32'h8000_0001, 32'h1234_56A5, 32'h0, 1, 32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0));
    vecs.push_back(mk("sw",     2'd2, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0));
    vecs.push_back(mk("lh",     2'd1, 3'd1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1, 32'h0, 4'h0, 32'h0, 32'hFFFF_8001, 1'b0));
    vecs.push_back(mk("lhu",    2'd1, 3'd5, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1, 32'h0, 4'h0, 32'h0, 32'h0000_8001, 1'b0));
    vecs.push_back(mk("lw",     2'd1, 3'd2, 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 1, 32'h4, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0));
    vecs.push_back(mk("lb pos", 2'd1, 3'd0, 32'h0000_0001, 32'h0, 32'h1234_7F00, 1, 32'h0, 4'h0, 32'h0, 32'h0000_007F, 1'b0));
    vecs.push_back(mk("ld f3=3", 2'd1, 3'd3, 32'h0000_0008, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("ld f3=6", 2'd1, 3'd6, 32'h0000_0008, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("st f3=3", 2'd2, 3'd3, 32'h0000_0008, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("op=3",   2'd3, 3'd0, 32'h0000_0008, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("lw mis", 2'd1, 3'd2, 32'h8000_0002, 32'h0, 32'h1122_3344, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("lh mis", 2'd1, 3'd1, 32'h0000_0003, 32'h0, 32'hAABB_CCDD, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("sh mis", 2'd2, 3'd1, 32'h0000_0001, 32'h0000_1234, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1));
`else
    vecs.push_back(mk("lw mis", 2'd1, 3'd2, 32'h8000_0002, 32'h0, 32'h1122_3344, 1, 32'h8000_0000, 4'h0, 32'h0, 32'h1122_3344, 1'b0));
    vecs.push_back(mk("lh mis", 2'd1, 3'd1, 32'h0000_0003, 32'h0, 32'hAABB_CCDD, 1, 32'h0, 4'h0, 32'h0, 32'hFFFF_AABB, 1'b0));
    vecs.push_back(mk("sh mis", 2'd2, 3'd1, 32'h0000_0001, 32'h0000_1234, 32'h0, 1, 32'h0, 4'b0011, 32'h1234_1234, 32'h0, 1'b0));
`endif

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_fault", {31'd0, out_fault}, 32'd0);
    chk("rst req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst req_addr", mem_req_addr, 32'd0);
    chk("rst req_wen", {31'd0, mem_req_wen}, 32'd0);
    chk("rst req_wdata", mem_req_wdata, 32'd0);
    chk("rst req_wmask", {28'd0, mem_req_wmask}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run(vecs[i], 0, 0, 0, vecs[i].req ? 2 : 0);

    // Request stall of 5 cycles, response after 2 WAIT cycles, writeback stall of 3 cycles
    v = mk("stall lw", 2'd1, 3'd2, 32'h0000_0024, 32'h0, 32'h0BAD_F00D, 1, 32'h24, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0);
    run(v, 5, 2, 3, 9);
    v = mk("stall sb", 2'd2, 3'd0, 32'h0000_0023, 32'h0000_00C3, 32'h0, 1, 32'h20, 4'b1000, 32'hC3C3_C3C3, 32'h0, 1'b0);
    run(v, 5, 1, 2, 8);

    // Response arriving in the last allowed WAIT cycle beats the timeout
    v = mk("edge resp", 2'd1, 3'd4, 32'h0000_0043, 32'h0, 32'h9A00_0000, 1, 32'h40, 4'h0, 32'h0, 32'h0000_009A, 1'b0);
    run(v, 0, 3, 0, 5);

    // No response: fault after 4 WAIT cycles, then a late response must be ignored
    v = mk("timeout", 2'd1, 3'd2, 32'h0000_0040, 32'h0, 32'h0, 1, 32'h40, 4'h0, 32'h0, 32'h0, 1'b1);
    run(v, 0, -1, 0, 5);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("late resp out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("late resp out_valid+1", {31'd0, out_valid}, 32'd0);
    chk("late resp in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a request
    in_valid = 1'b1; in_op = 2'd1; in_funct3 = 3'd2; in_addr = 32'h0000_0080;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst req before", {31'd0, mem_req_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst req dropped", {31'd0, mem_req_valid}, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst req idle", {31'd0, mem_req_valid}, 32'd0);
    chk("midrst in_ready after", {31'd0, in_ready}, 32'd1);

    // Pass-through still works after everything above
    v = mk("none again", 2'd0, 3'd7, 32'hA5A5_0001, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'hA5A5_0001, 1'b0);
    run(v, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store stage directly downstream of the execute unit. Consumes the ALU result as the effective address (or as a pass-through result) and performs at most one data-memory transaction per instruction over a valid/ready request and response bus.
- Delivers the aligned, sign- or zero-extended load data, or the pass-through value, to writeback through a valid/ready handshake.
- Holds one instruction at a time; there is no pipelining inside the block.

Parameters:
- RESP_TIMEOUT, 255: maximum number of WAIT cycles before the access is abandoned with a fault; legal range 1..65535.
- CNT_W, 16: width of the timeout counter; RESP_TIMEOUT must fit in CNT_W bits.

Ports:
- clk input 1: system clock; all state updates on the rising edge.
- rst input 1: asynchronous, active-high reset.
- in_valid input 1: execute result is valid.
- in_ready output 1: block can accept an instruction.
- in_op input 2: 0 NONE (pass-through), 1 LOAD, 2 STORE, 3 reserved (faults).
- in_funct3 input 3: RV32I width/sign code.
- in_addr input 32: ALU output; effective address, or the result when in_op is NONE.
- in_wdata input 32: store data (rs2).
- out_valid output 1: result available to writeback.
- out_ready input 1: writeback accepts the result.
- out_data output 32: load data or pass-through value.
- out_fault output 1: access fault; qualified by out_valid.
- mem_req_valid output 1: memory request valid.
- mem_req_ready input 1: memory accepts the request.
- mem_req_addr output 32: word-aligned address, {addr[31:2],2'b00}.
- mem_req_wen output 1: 1 for store, 0 for load.
- mem_req_wdata output 32: store data shifted into its byte lanes.
- mem_req_wmask output 4: byte-lane write enables; 0 for loads.
- mem_resp_valid input 1: memory response valid; always accepted, no backpressure.
- mem_resp_rdata input 32: read word.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset sets state to IDLE and clears every registered output (out_valid, out_data, out_fault, mem_req_*) to 0.
- in_ready = (state==IDLE) & ~rst. Instruction is accepted on in_valid & in_ready; op, funct3, addr and wdata are latched at that edge.
- On accept:
  - NONE: go to DONE with out_data = in_addr and out_fault = 0.
  - Illegal code (op=3; LOAD with funct3 3/6/7; STORE with funct3 >= 3): go to DONE with out_fault = 1 and out_data = 0. No memory request is issued.
  - Otherwise: go to REQ.
- REQ: mem_req_valid = 1 with address, wen, wdata and wmask held stable. On mem_req_ready, go to WAIT and clear the timeout counter.
- WAIT: the counter increments each cycle.
  - On mem_resp_valid: go to DONE. A load produces the extracted data; a store produces out_data = 0.
  - If the counter reaches RESP_TIMEOUT without a response: go to DONE with out_fault = 1 and out_data = 0.
  - If mem_resp_valid and timeout coincide, the response wins and there is no fault.
- DONE: out_valid = 1 and out_data/out_fault are held stable until out_ready; then return to IDLE. The earliest new accept is the cycle after returning to IDLE.
- mem_resp_valid outside WAIT is ignored, including late responses after a timeout.
- Byte lane is addr[1:0]:
  - SB: wmask = 4'b0001 << addr[1:0], wdata = {4{byte}}.
  - SH: wmask = 4'b0011 << addr[1:0], wdata = {2{half}}.
  - SW: wmask = 4'b1111.
  - Loads: shift the read word right by 8*addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW is unmodified.
- Latency:
  - NONE: out_valid the cycle after accept.
  - Zero-wait memory (ready on first REQ cycle, response the cycle after): out_valid 3 cycles after accept.
- Reset mid-operation forces IDLE immediately and drops mem_req_valid. A response arriving afterwards is ignored.

Optional Feature:
- LSU_MISALIGN_TRAP_EN.
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]≠0, goes straight to DONE with out_fault = 1 and issues no memory request.
- Undefined: the low offset bits are forced to 0 for halfword (addr[0]) and word (addr[1:0]) accesses, and the access proceeds aligned with no fault.

Decomposition:
- Shared package: the op encoding (LSU_NONE/LOAD/STORE), the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state encoding.
- One sub-module, lsu_align: combinational store lane shifting with wmask generation, plus load extraction and extension. Used once.

Test Plan:
- NONE op, in_addr=0x1234_5678 -> out_valid next cycle, out_data=0x1234_5678, no mem_req_valid.
- LB addr=0x8000_0003, rdata=0x8000_0000 -> mem_req_addr=0x8000_0000, wmask=0, out_data=0xFFFF_FF80. LBU on the same data -> 0x0000_0080.
- SH addr=0x8000_0002, wdata=0x0000_BEEF -> wmask=4'b1100, mem_req_wdata=0xBEEF_BEEF, mem_req_wen=1.
- mem_req_ready held low 5 cycles, then response -> mem_req_* stable throughout; out_valid held 3 cycles with out_ready low, out_data unchanged.
- RESP_TIMEOUT=4, no response -> out_fault=1 after 4 WAIT cycles; a late mem_resp_valid in IDLE is ignored.
- LW addr=0x8000_0002 -> with LSU_MISALIGN_TRAP_EN: fault and no request. Without it: mem_req_addr=0x8000_0000 and no fault. LB funct3=3 -> fault with no request in both builds.
